// File: rtl/status_link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : status_link_receiver
// Purpose  : Keypad/remote-panel end of the alarm status link. Deserializes
//            STATUS_SEND-framed bursts (MSB first), presents each good status
//            word with a one-cycle valid strobe, pulses FRAME_ERR on short,
//            long or bad-parity frames, and raises LINK_LOST when no good
//            frame has arrived for TIMEOUT cycles.
// Options  : define STATUS_PARITY_EN to expect one trailing even-parity bit
//            per frame (parity bit is not stored in STATUS_WORD).
// Revision : 1.0 - initial release
// ============================================================================
module status_link_receiver #(
  parameter int WIDTH   = 4,   // status bits per frame, WIDTH >= 2
  parameter int TIMEOUT = 64   // watchdog limit in cycles, TIMEOUT >= 2
) (
  input  logic             SERCLK_IN,
  input  logic             RESET_IN,
  input  logic             STATUS_IN,
  input  logic             STATUS_SEND_IN,
  output logic [WIDTH-1:0] STATUS_WORD,
  output logic             STATUS_VALID,
  output logic             FRAME_ERR,
  output logic             LINK_LOST
);

`ifdef STATUS_PARITY_EN
  localparam int c_FRAME_LEN = WIDTH + 1;
`else
  localparam int c_FRAME_LEN = WIDTH;
`endif

  // Bit counter must reach FRAME_LEN+1 so an over-long burst stays distinguishable.
  localparam int c_CNT_W = $clog2(c_FRAME_LEN + 2);
  localparam int c_WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [c_CNT_W-1:0] c_N_FRAME = c_CNT_W'(c_FRAME_LEN);
  localparam logic [c_CNT_W-1:0] c_N_SAT   = c_CNT_W'(c_FRAME_LEN + 1);
  localparam logic [c_WD_W-1:0]  c_WD_MAX  = c_WD_W'(TIMEOUT);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  logic [0:0]             r_state;
  logic [0:0]             w_state_next;
  logic                   w_sample;
  logic                   w_eval;
  logic [c_FRAME_LEN-1:0] r_shift;
  logic [c_CNT_W-1:0]     r_count;
  logic [c_WD_W-1:0]      r_wd;
  logic [c_WD_W-1:0]      w_wd_next;
  logic [WIDTH-1:0]       r_word;
  logic [WIDTH-1:0]       w_word;
  logic                   w_par_ok;
  logic                   w_good;
  logic                   w_bad;
  logic                   r_valid;
  logic                   r_err;
  logic                   r_lost;

`ifdef STATUS_PARITY_EN
  // Parity bit is the last one shifted in, so it sits in the LSB.
  assign w_word   = r_shift[c_FRAME_LEN-1:1];
  assign w_par_ok = ~^r_shift;
`else
  assign w_word   = r_shift;
  assign w_par_ok = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge SERCLK_IN) begin
    if (RESET_IN) r_state <= c_ST_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM next state: a burst runs for as long as SEND is held high
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE:  if (STATUS_SEND_IN)  w_state_next = c_ST_SHIFT;
      c_ST_SHIFT: if (!STATUS_SEND_IN) w_state_next = c_ST_IDLE;
      default:    w_state_next = c_ST_IDLE;
    endcase
  end

  // FSM outputs: sample on every SEND edge, evaluate on the first SEND=0 edge of a burst
  always_comb begin
    w_sample = STATUS_SEND_IN;
    w_eval   = (r_state == c_ST_SHIFT) && !STATUS_SEND_IN;
  end

  assign w_good = w_eval && (r_count == c_N_FRAME) && w_par_ok;
  assign w_bad  = w_eval && !w_good;

  // Shift register and saturating bit counter; counter clears between bursts
  always_ff @(posedge SERCLK_IN) begin
    if (RESET_IN) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_sample) begin
      r_shift <= {r_shift[c_FRAME_LEN-2:0], STATUS_IN};
      if (r_count != c_N_SAT) r_count <= r_count + c_CNT_W'(1);
    end else begin
      r_count <= '0;
    end
  end

  // Registered frame verdict: word load plus mutually exclusive strobes
  always_ff @(posedge SERCLK_IN) begin
    if (RESET_IN) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_good;
      r_err   <= w_bad;
      if (w_good) r_word <= w_word;
    end
  end

  // Watchdog next value: a good frame clears it, otherwise count up to TIMEOUT
  always_comb begin
    w_wd_next = r_wd;
    if (w_good)                 w_wd_next = '0;
    else if (r_wd != c_WD_MAX)  w_wd_next = r_wd + c_WD_W'(1);
  end

  // Watchdog register; LINK_LOST follows the count reaching TIMEOUT on the same edge
  always_ff @(posedge SERCLK_IN) begin
    if (RESET_IN) begin
      r_wd   <= '0;
      r_lost <= 1'b0;
    end else begin
      r_wd   <= w_wd_next;
      r_lost <= (w_wd_next == c_WD_MAX);
    end
  end

  assign STATUS_WORD  = r_word;
  assign STATUS_VALID = r_valid;
  assign FRAME_ERR    = r_err;
  assign LINK_LOST    = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_status_link_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_link_receiver
// Purpose  : Self-checking bench for status_link_receiver. Directed scenarios
//            followed by random bursts, compared every cycle against a
//            frame-level model (bit queue per burst, quiet-cycle counter).
// Options  : honours STATUS_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_link_receiver;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 64;
`ifdef STATUS_PARITY_EN
  localparam int  FLEN = WIDTH + 1;
  localparam bit  PAR  = 1'b1;
`else
  localparam int  FLEN = WIDTH;
  localparam bit  PAR  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             sdat;
  logic             ssend;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             ferr;
  logic             lost;

  always #5 clk = ~clk;

  status_link_receiver #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .SERCLK_IN      (clk),
    .RESET_IN       (rst),
    .STATUS_IN      (sdat),
    .STATUS_SEND_IN (ssend),
    .STATUS_WORD    (word),
    .STATUS_VALID   (valid),
    .FRAME_ERR      (ferr),
    .LINK_LOST      (lost)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: bits of the burst in progress, cycles since last good frame
  bit               m_bits[$];
  bit               m_busy  = 1'b0;
  int               m_quiet = 0;
  logic [WIDTH-1:0] m_word  = '0;
  bit               m_valid = 1'b0;
  bit               m_err   = 1'b0;

  int valid_cnt = 0;
  int err_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model of one clock edge with the given inputs
  task automatic model_edge(input bit r, input bit s, input bit d);
    int  ones;
    int  val;
    bit  good;
    m_valid = 1'b0;
    m_err   = 1'b0;
    good    = 1'b0;
    if (r) begin
      m_bits.delete();
      m_busy  = 1'b0;
      m_quiet = 0;
      m_word  = '0;
      return;
    end
    if (s) begin
      m_bits.push_back(d);
      m_busy = 1'b1;
    end else if (m_busy) begin
      ones = 0;
      foreach (m_bits[i]) ones += int'(m_bits[i]);
      if (m_bits.size() == FLEN && (!PAR || (ones % 2 == 0))) begin
        val = 0;
        for (int i = 0; i < WIDTH; i++) val = val * 2 + int'(m_bits[i]);
        m_word  = WIDTH'(val);
        m_valid = 1'b1;
        good    = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_bits.delete();
      m_busy = 1'b0;
    end
    if (good)                   m_quiet = 0;
    else if (m_quiet < TIMEOUT) m_quiet++;
  endtask

  // One clock: drive, let the edge happen, compare just after it
  task automatic step(input bit r, input bit s, input bit d);
    rst   = r;
    ssend = s;
    sdat  = d;
    @(posedge clk);
    #1;
    model_edge(r, s, d);
    check("word",  32'(word),  32'(m_word));
    check("valid", 32'(valid), 32'(m_valid));
    check("ferr",  32'(ferr),  32'(m_err));
    check("lost",  32'(lost),  32'(m_quiet >= TIMEOUT));
    if (valid) valid_cnt++;
    if (ferr)  err_cnt++;
  endtask

  // Burst of len bits taken MSB-first from pat, then one SEND=0 edge
  task automatic burst(input int len, input logic [15:0] pat);
    logic [15:0] p;
    p = pat;
    for (int i = len - 1; i >= 0; i--) step(1'b0, 1'b1, p[i]);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Well-formed frame for a WIDTH-bit word, parity appended when enabled
  task automatic good_frame(input logic [WIDTH-1:0] w);
    if (PAR) burst(FLEN, {11'd0, w, ^w});
    else     burst(FLEN, {12'd0, w});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  int v0;
  int e0;
  int len;
  logic [15:0] pat;

  initial begin
    rst = 1'b1; ssend = 1'b0; sdat = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("reset_word", 32'(word), 32'd0);
    check("reset_lost", 32'(lost), 32'd0);

    // Single good frame 1011
    good_frame(4'b1011);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_word",  32'(word),  32'hB);
    idle(1);

    // Short then long frame
    v0 = valid_cnt; e0 = err_cnt;
    burst(3, 16'b110);
    burst(FLEN + 1, 16'b0110_1);
    idle(1);
    check("t2_errs",   32'(err_cnt - e0),   32'd2);
    check("t2_valids", 32'(valid_cnt - v0), 32'd0);
    check("t2_word",   32'(word),           32'hB);

    // Back-to-back good frames
    v0 = valid_cnt;
    good_frame(4'b0001);
    good_frame(4'b1110);
    idle(1);
    check("t3_valids", 32'(valid_cnt - v0), 32'd2);
    check("t3_word",   32'(word),           32'hE);

    // Watchdog expiry after reset, cleared by a good frame
    step(1'b1, 1'b0, 1'b0);
    idle(TIMEOUT - 1);
    check("t4_lost_63", 32'(lost), 32'd0);
    idle(1);
    check("t4_lost_64", 32'(lost), 32'd1);
    good_frame(4'b0101);
    check("t4_valid",   32'(valid), 32'd1);
    check("t4_cleared", 32'(lost),  32'd0);

    // Good frame ending on the expiry edge keeps LINK_LOST low
    step(1'b1, 1'b0, 1'b0);
    idle(TIMEOUT - 1 - FLEN);
    good_frame(4'b0110);
    check("t4b_valid", 32'(valid), 32'd1);
    check("t4b_lost",  32'(lost),  32'd0);

    // Reset after two bits of a burst discards it
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("t5_word",  32'(word),  32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_ferr",  32'(ferr),  32'd0);
    good_frame(4'b1001);
    check("t5_word2", 32'(word), 32'h9);

`ifdef STATUS_PARITY_EN
    // Parity accepted / rejected
    burst(5, 16'b1011_1);
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_word",  32'(word),  32'hB);
    burst(5, 16'b1011_0);
    check("t6_ferr",  32'(ferr),  32'd1);
    check("t6_word2", 32'(word),  32'hB);
`endif

    // Random bursts, gaps, long idles and occasional resets
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 11))
        0:       step(1'b1, 1'(($urandom_range(0, 1))), 1'b0);
        1:       idle($urandom_range(55, 70));
        default: begin
          len = $urandom_range(1, FLEN + 2);
          pat = 16'($urandom);
          if (PAR && len == FLEN && $urandom_range(0, 1) == 1) begin
            pat[0] = 1'b0;
            pat[0] = ^(pat & 16'((1 << FLEN) - 1));
          end
          for (int i = len - 1; i >= 0; i--) begin
            if ($urandom_range(0, 59) == 0) step(1'b1, 1'b1, pat[i]);
            else                             step(1'b0, 1'b1, pat[i]);
          end
          step(1'b0, 1'b0, 1'b0);
          idle($urandom_range(0, 2));
        end
      endcase
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
